regfile_sb: RTL and testbench

Parametrised successor to the 4×16 MIPS register file. It provides `NREG = 2**ADDR_W` registers of `WIDTH` bits, two combinational read ports and one synchronous write port. Register 0 is hardwired to zero. The block adds an asynchronous clear, optional write-to-read bypass, and a per-register busy scoreboard so the datapath can stall on reads of registers with an outstanding (multi-cycle) writeback. It sits between instruction decode (read/issue) and writeback in the project CPU.

---
 rtl/regfile_sb_if.sv | 37 +++
 rtl/regfile_sb.sv | 80 ++++++++
 tb/tb_regfile_sb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Bus bundle between the datapath and the scoreboarded
//                register file: two read ports with their busy flags, one
//                writeback port and one issue port.
//                master - datapath side (drives addresses, write and issue)
//                slave  - register file side (returns read data and busy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] rr1;
  logic [ADDR_W-1:0] rr2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              busy1;
  logic              busy2;
  logic              regwrite;
  logic [ADDR_W-1:0] wr;
  logic [WIDTH-1:0]  wd;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_reg;

  modport master (
    output rr1, rr2, regwrite, wr, wd, iss_valid, iss_reg,
    input  rd1, rd2, busy1, busy2
  );

  modport slave (
    input  rr1, rr2, regwrite, wr, wd, iss_valid, iss_reg,
    output rd1, rd2, busy1, busy2
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : 2**ADDR_W x WIDTH register file, register 0 hardwired to
//                zero. Two combinational read ports, one synchronous write
//                port, optional same-cycle write-to-read bypass and a
//                per-register busy scoreboard for outstanding writebacks.
//  Ports       : clock   - rising-edge clock
//                reset_n - asynchronous active-low clear of data and busy
//                bus     - regfile_sb_if.slave (read, writeback, issue)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  regfile_sb_if.slave   bus
);

  localparam int c_NREG = 2 ** ADDR_W;

  // Flattened view of the state, with entry 0 tied to zero so the read
  // muxes can index directly by address.
  logic [WIDTH-1:0]  w_regs [c_NREG];
  logic [c_NREG-1:0] w_busy;

  logic w_wr_valid;
  logic w_hit1;
  logic w_hit2;

  assign w_regs[0] = '0;
  assign w_busy[0] = 1'b0;

  assign w_wr_valid = bus.regwrite && (bus.wr != '0);

  generate
    for (genvar i = 1; i < c_NREG; i++) begin : g_reg
      logic [WIDTH-1:0] r_data;
      logic             r_busy;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (bus.regwrite && (bus.wr == ADDR_W'(i))) begin
            r_data <= bus.wd;
          end
          // A new issue marks a younger outstanding write, so it takes
          // precedence over a writeback landing on the same register.
          if (bus.iss_valid && (bus.iss_reg == ADDR_W'(i))) begin
            r_busy <= 1'b1;
          end else if (bus.regwrite && (bus.wr == ADDR_W'(i))) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_regs[i] = r_data;
      assign w_busy[i] = r_busy;
    end
  endgenerate

  // Forwarding hits: the writeback in flight satisfies the read, so the
  // reader sees the new data and must not stall on it.
  assign w_hit1 = (BYPASS != 0) && w_wr_valid && (bus.wr == bus.rr1);
  assign w_hit2 = (BYPASS != 0) && w_wr_valid && (bus.wr == bus.rr2);

  // Outputs are forced quiet while reset is held so a pending write cannot
  // leak through the bypass path.
  assign bus.rd1   = !reset_n ? '0 : (w_hit1 ? bus.wd : w_regs[bus.rr1]);
  assign bus.rd2   = !reset_n ? '0 : (w_hit2 ? bus.wd : w_regs[bus.rr2]);
  assign bus.busy1 = reset_n && !w_hit1 && w_busy[bus.rr1];
  assign bus.busy2 = reset_n && !w_hit2 && w_busy[bus.rr2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb. Two 16x4 instances
//                (bypass on / off) share stimulus; a 32x32 instance covers
//                the wide configuration. Expected values come from constants
//                and an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  regfile_sb_if #(.WIDTH(16), .ADDR_W(2)) ifa ();
  regfile_sb_if #(.WIDTH(16), .ADDR_W(2)) ifb ();
  regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) ifc ();

  regfile_sb #(.WIDTH(16), .ADDR_W(2), .BYPASS(1)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
  regfile_sb #(.WIDTH(16), .ADDR_W(2), .BYPASS(0)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));
  regfile_sb #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut_c (.clock(clock), .reset_n(reset_n), .bus(ifc));

  int total = 0;
  int bad   = 0;

  // Reference model: register contents and outstanding-write flags.
  logic [15:0] m_reg  [4];
  bit          m_busy [4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 0;
    end
  endtask

  task automatic drive16(input logic [1:0] rr1, input logic [1:0] rr2,
                         input logic we, input logic [1:0] wr, input logic [15:0] wd,
                         input logic iv, input logic [1:0] ir);
    ifa.rr1 = rr1; ifa.rr2 = rr2; ifa.regwrite = we; ifa.wr = wr; ifa.wd = wd;
    ifa.iss_valid = iv; ifa.iss_reg = ir;
    ifb.rr1 = rr1; ifb.rr2 = rr2; ifb.regwrite = we; ifb.wr = wr; ifb.wd = wd;
    ifb.iss_valid = iv; ifb.iss_reg = ir;
  endtask

  // Apply this cycle's write/issue to the model, then take the clock edge.
  task automatic edge16();
    if (ifa.regwrite && ifa.wr != 2'd0) begin
      m_reg[ifa.wr]  = ifa.wd;
      m_busy[ifa.wr] = 0;
    end
    if (ifa.iss_valid && ifa.iss_reg != 2'd0) m_busy[ifa.iss_reg] = 1;
    @(posedge clock);
  endtask

  function automatic logic [15:0] exp_rd(input logic [1:0] rr, input bit byp);
    if (rr == 2'd0) return 16'h0;
    if (byp && ifa.regwrite && ifa.wr == rr) return ifa.wd;
    return m_reg[rr];
  endfunction

  function automatic logic exp_busy(input logic [1:0] rr, input bit byp);
    if (rr == 2'd0) return 1'b0;
    if (byp && ifa.regwrite && ifa.wr == rr) return 1'b0;
    return m_busy[rr];
  endfunction

  task automatic test_reset();
    drive16(2'd1, 2'd3, 1'b1, 2'd1, 16'hFFFF, 1'b1, 2'd1);
    #3;
    total++; if (ifa.rd1 !== 16'h0) begin bad++; $display("FAIL reset_a_rd1 got=%h exp=0000", ifa.rd1); end
    total++; if (ifa.rd2 !== 16'h0) begin bad++; $display("FAIL reset_a_rd2 got=%h exp=0000", ifa.rd2); end
    total++; if (ifa.busy1 !== 1'b0) begin bad++; $display("FAIL reset_a_busy1 got=%b exp=0", ifa.busy1); end
    total++; if (ifa.busy2 !== 1'b0) begin bad++; $display("FAIL reset_a_busy2 got=%b exp=0", ifa.busy2); end
    total++; if (ifb.rd1 !== 16'h0) begin bad++; $display("FAIL reset_b_rd1 got=%h exp=0000", ifb.rd1); end
    total++; if (ifb.busy2 !== 1'b0) begin bad++; $display("FAIL reset_b_busy2 got=%b exp=0", ifb.busy2); end
    // Anything presented during reset is discarded.
    @(negedge clock);
    reset_n = 1'b1;
    drive16(2'd1, 2'd3, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    #1;
    total++; if (ifa.rd1 !== 16'h0) begin bad++; $display("FAIL reset_discard_rd1 got=%h exp=0000", ifa.rd1); end
    total++; if (ifa.busy1 !== 1'b0) begin bad++; $display("FAIL reset_discard_busy1 got=%b exp=0", ifa.busy1); end
    // Write BEEF to r2, then pulse reset mid-cycle.
    @(negedge clock);
    drive16(2'd2, 2'd2, 1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd0);
    edge16();
    #1;
    ifa.regwrite = 1'b0; ifb.regwrite = 1'b0;
    #1;
    total++; if (ifa.rd1 !== 16'hBEEF) begin bad++; $display("FAIL reset_pre_beef got=%h exp=beef", ifa.rd1); end
    reset_n = 1'b0;
    #1;
    total++; if (ifa.rd1 !== 16'h0) begin bad++; $display("FAIL reset_async_a got=%h exp=0000", ifa.rd1); end
    total++; if (ifb.rd2 !== 16'h0) begin bad++; $display("FAIL reset_async_b got=%h exp=0000", ifb.rd2); end
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [15:0] vals [4];
    logic [15:0] e;
    vals[0] = 16'hFFFF; vals[1] = 16'h1111; vals[2] = 16'h2222; vals[3] = 16'h3333;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      drive16(2'd0, 2'd0, 1'b1, 2'(i % 4), vals[i % 4], 1'b0, 2'd0);
      edge16();
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clock);
      drive16(2'(r), 2'(3 - r), 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
      #1;
      e = (r == 0) ? 16'h0 : vals[r];
      total++; if (ifa.rd1 !== e) begin bad++; $display("FAIL wr_rd_a r%0d got=%h exp=%h", r, ifa.rd1, e); end
      total++; if (ifb.rd1 !== e) begin bad++; $display("FAIL wr_rd_b r%0d got=%h exp=%h", r, ifb.rd1, e); end
    end
    @(negedge clock);
    drive16(2'd1, 2'd1, 1'b0, 2'd1, 16'hAAAA, 1'b0, 2'd0);
    edge16();
    @(negedge clock);
    #1;
    total++; if (ifa.rd1 !== 16'h1111) begin bad++; $display("FAIL no_write_hold got=%h exp=1111", ifa.rd1); end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    drive16(2'd2, 2'd2, 1'b1, 2'd2, 16'h5A5A, 1'b0, 2'd0);
    #1;
    total++; if (ifa.rd1 !== 16'h5A5A) begin bad++; $display("FAIL byp_on_rd1 got=%h exp=5a5a", ifa.rd1); end
    total++; if (ifa.rd2 !== 16'h5A5A) begin bad++; $display("FAIL byp_on_rd2 got=%h exp=5a5a", ifa.rd2); end
    total++; if (ifb.rd1 !== 16'h2222) begin bad++; $display("FAIL byp_off_old got=%h exp=2222", ifb.rd1); end
    edge16();
    @(negedge clock);
    drive16(2'd2, 2'd2, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    #1;
    total++; if (ifb.rd1 !== 16'h5A5A) begin bad++; $display("FAIL byp_off_new got=%h exp=5a5a", ifb.rd1); end
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    drive16(2'd3, 2'd3, 1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
    #1;
    total++; if (ifa.busy1 !== 1'b0) begin bad++; $display("FAIL sb_issue_cycle got=%b exp=0", ifa.busy1); end
    edge16();
    @(negedge clock);
    drive16(2'd3, 2'd3, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    #1;
    total++; if (ifa.busy1 !== 1'b1) begin bad++; $display("FAIL sb_busy_a got=%b exp=1", ifa.busy1); end
    total++; if (ifb.busy2 !== 1'b1) begin bad++; $display("FAIL sb_busy_b got=%b exp=1", ifb.busy2); end
    @(negedge clock);
    drive16(2'd3, 2'd3, 1'b1, 2'd3, 16'h0042, 1'b0, 2'd0);
    #1;
    total++; if (ifa.busy1 !== 1'b0) begin bad++; $display("FAIL sb_wb_byp_busy got=%b exp=0", ifa.busy1); end
    total++; if (ifa.rd1 !== 16'h0042) begin bad++; $display("FAIL sb_wb_byp_rd got=%h exp=0042", ifa.rd1); end
    total++; if (ifb.busy1 !== 1'b1) begin bad++; $display("FAIL sb_wb_nobyp_busy got=%b exp=1", ifb.busy1); end
    edge16();
    @(negedge clock);
    drive16(2'd3, 2'd3, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    #1;
    total++; if (ifa.busy1 !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", ifa.busy1); end
    total++; if (ifb.rd1 !== 16'h0042) begin bad++; $display("FAIL sb_wb_data got=%h exp=0042", ifb.rd1); end
  endtask

  task automatic test_issue_wb_same();
    @(negedge clock);
    drive16(2'd1, 2'd1, 1'b1, 2'd1, 16'h7777, 1'b1, 2'd1);
    edge16();
    @(negedge clock);
    drive16(2'd1, 2'd0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
    #1;
    total++; if (ifa.busy1 !== 1'b1) begin bad++; $display("FAIL iss_wins_busy got=%b exp=1", ifa.busy1); end
    total++; if (ifb.rd1 !== 16'h7777) begin bad++; $display("FAIL iss_wins_data got=%h exp=7777", ifb.rd1); end
    edge16();
    @(negedge clock);
    drive16(2'd0, 2'd1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    #1;
    total++; if (ifa.busy1 !== 1'b0) begin bad++; $display("FAIL iss_r0_busy got=%b exp=0", ifa.busy1); end
    total++; if (ifa.rd1 !== 16'h0) begin bad++; $display("FAIL iss_r0_rd got=%h exp=0000", ifa.rd1); end
    total++; if (ifa.busy2 !== 1'b1) begin bad++; $display("FAIL iss_r1_still got=%b exp=1", ifa.busy2); end
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic        eb;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      drive16(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
              1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
      #1;
      e = exp_rd(ifa.rr1, 1);
      total++; if (ifa.rd1 !== e) begin bad++; $display("FAIL rnd_a_rd1 n=%0d got=%h exp=%h", n, ifa.rd1, e); end
      e = exp_rd(ifa.rr2, 1);
      total++; if (ifa.rd2 !== e) begin bad++; $display("FAIL rnd_a_rd2 n=%0d got=%h exp=%h", n, ifa.rd2, e); end
      eb = exp_busy(ifa.rr1, 1);
      total++; if (ifa.busy1 !== eb) begin bad++; $display("FAIL rnd_a_busy1 n=%0d got=%b exp=%b", n, ifa.busy1, eb); end
      eb = exp_busy(ifa.rr2, 1);
      total++; if (ifa.busy2 !== eb) begin bad++; $display("FAIL rnd_a_busy2 n=%0d got=%b exp=%b", n, ifa.busy2, eb); end
      e = exp_rd(ifb.rr1, 0);
      total++; if (ifb.rd1 !== e) begin bad++; $display("FAIL rnd_b_rd1 n=%0d got=%h exp=%h", n, ifb.rd1, e); end
      e = exp_rd(ifb.rr2, 0);
      total++; if (ifb.rd2 !== e) begin bad++; $display("FAIL rnd_b_rd2 n=%0d got=%h exp=%h", n, ifb.rd2, e); end
      eb = exp_busy(ifb.rr1, 0);
      total++; if (ifb.busy1 !== eb) begin bad++; $display("FAIL rnd_b_busy1 n=%0d got=%b exp=%b", n, ifb.busy1, eb); end
      eb = exp_busy(ifb.rr2, 0);
      total++; if (ifb.busy2 !== eb) begin bad++; $display("FAIL rnd_b_busy2 n=%0d got=%b exp=%b", n, ifb.busy2, eb); end
      edge16();
    end
    @(negedge clock);
    drive16(2'd0, 2'd0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
  endtask

  task automatic test_param();
    logic [31:0] e;
    logic        eb;
    @(negedge clock);
    ifc.iss_valid = 1'b1; ifc.iss_reg = 5'd7;
    @(posedge clock);
    @(negedge clock);
    ifc.iss_valid = 1'b0;
    ifc.regwrite = 1'b1; ifc.wr = 5'd31; ifc.wd = 32'hDEADBEEF;
    ifc.rr1 = 5'd31; ifc.rr2 = 5'd31;
    #1;
    total++; if (ifc.rd1 !== 32'hDEADBEEF) begin bad++; $display("FAIL p32_bypass got=%h exp=deadbeef", ifc.rd1); end
    @(posedge clock);
    @(negedge clock);
    ifc.regwrite = 1'b0;
    for (int r = 0; r < 32; r++) begin
      ifc.rr1 = 5'(r);
      #1;
      e  = (r == 31) ? 32'hDEADBEEF : 32'h0;
      eb = (r == 7);
      total++; if (ifc.rd1 !== e) begin bad++; $display("FAIL p32_rd r%0d got=%h exp=%h", r, ifc.rd1, e); end
      total++; if (ifc.busy1 !== eb) begin bad++; $display("FAIL p32_busy r%0d got=%b exp=%b", r, ifc.busy1, eb); end
    end
    total++; if (ifc.rd2 !== 32'hDEADBEEF) begin bad++; $display("FAIL p32_rd2 got=%h exp=deadbeef", ifc.rd2); end
  endtask

  initial begin
    model_clear();
    ifc.rr1 = '0; ifc.rr2 = '0; ifc.regwrite = 1'b0; ifc.wr = '0; ifc.wd = '0;
    ifc.iss_valid = 1'b0; ifc.iss_reg = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_issue_wb_same();
    test_random();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
